// File: rtl/bcd_rtc_core.sv
// BCD time-of-day core: prescales clk to a 1 Hz advance and keeps hh:mm:ss
// with up/down counting, validated load, alarm match and 12/24-hour output.
module bcd_rtc_core #(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       dir,
    input  logic       fmt12,
    input  logic       load,
    input  logic       alarm_set,
    input  logic       alarm_en,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       tick,
    output logic       alarm,
    output logic       zero,
    output logic       err
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic [7:0]    t_hh, t_mm, t_ss;
    logic [7:0]    a_hh, a_mm, a_ss;

    logic       adv, ld_ok, load_acc, step_ok, is_zero, is_one;
    logic       s_wrap, m_wrap, s_borrow, m_borrow;
    logic [7:0] n_hh, n_mm, n_ss;
    logic [7:0] h12;

    // Two-digit BCD increment; returns 00 after reaching max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Two-digit BCD decrement; returns max when leaving 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == 8'h00)
            r = max;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Next-time computation and strobe qualification
    always_comb begin
        adv      = run && (presc == PS_MAX);
        ld_ok    = bcd_valid(ld_hh, 8'h23) && bcd_valid(ld_mm, 8'h59) && bcd_valid(ld_ss, 8'h59);
        load_acc = load && ld_ok;
        is_zero  = (t_hh == 8'h00) && (t_mm == 8'h00) && (t_ss == 8'h00);
        is_one   = (t_hh == 8'h00) && (t_mm == 8'h00) && (t_ss == 8'h01);
        step_ok  = adv && !(dir && is_zero);

        s_wrap   = (t_ss == 8'h59);
        m_wrap   = (t_mm == 8'h59);
        s_borrow = (t_ss == 8'h00);
        m_borrow = (t_mm == 8'h00);

        n_hh = t_hh;
        n_mm = t_mm;
        n_ss = t_ss;
        if (!dir) begin
            n_ss = bcd_inc(t_ss, 8'h59);
            if (s_wrap)
                n_mm = bcd_inc(t_mm, 8'h59);
            if (s_wrap && m_wrap)
                n_hh = bcd_inc(t_hh, 8'h23);
        end else begin
            n_ss = bcd_dec(t_ss, 8'h59);
            if (s_borrow)
                n_mm = bcd_dec(t_mm, 8'h59);
            if (s_borrow && m_borrow)
                n_hh = bcd_dec(t_hh, 8'h23);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            t_hh  <= 8'h00;
            t_mm  <= 8'h00;
            t_ss  <= 8'h00;
            a_hh  <= 8'h00;
            a_mm  <= 8'h00;
            a_ss  <= 8'h00;
            tick  <= 1'b0;
            alarm <= 1'b0;
            zero  <= 1'b0;
            err   <= 1'b0;
        end else begin
            tick  <= 1'b0;
            alarm <= 1'b0;
            zero  <= 1'b0;
            err   <= (load || alarm_set) && !ld_ok;

            if (load_acc)
                presc <= '0;
            else if (run)
                presc <= (presc == PS_MAX) ? '0 : presc + PW'(1);

            if (load_acc) begin
                t_hh <= ld_hh;
                t_mm <= ld_mm;
                t_ss <= ld_ss;
            end else if (step_ok) begin
                t_hh  <= n_hh;
                t_mm  <= n_mm;
                t_ss  <= n_ss;
                tick  <= 1'b1;
                alarm <= alarm_en && (n_hh == a_hh) && (n_mm == a_mm) && (n_ss == a_ss);
                zero  <= dir && is_one;
            end

            if (alarm_set && ld_ok) begin
                a_hh <= ld_hh;
                a_mm <= ld_mm;
                a_ss <= ld_ss;
            end
        end
    end

    // 12-hour view of the internal 24-hour register
    always_comb begin
        case (t_hh)
            8'h00:   h12 = 8'h12;
            8'h13:   h12 = 8'h01;
            8'h14:   h12 = 8'h02;
            8'h15:   h12 = 8'h03;
            8'h16:   h12 = 8'h04;
            8'h17:   h12 = 8'h05;
            8'h18:   h12 = 8'h06;
            8'h19:   h12 = 8'h07;
            8'h20:   h12 = 8'h08;
            8'h21:   h12 = 8'h09;
            8'h22:   h12 = 8'h10;
            8'h23:   h12 = 8'h11;
            default: h12 = t_hh;
        endcase
        pm = (t_hh >= 8'h12);
        hh = fmt12 ? h12 : t_hh;
        mm = t_mm;
        ss = t_ss;
    end

endmodule
